// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: RISC-V opcode constants, the bubble
// instruction word and the RUN/HALT state encoding.
package fetch_stage_pkg;

    // RISC-V base opcodes used by fetch.
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] HALT_OPCODE = 7'b1111111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

    typedef enum logic {
        StRun  = 1'b0,
        StHalt = 1'b1
    } fetch_state_e;

    function automatic logic is_halt(input logic [31:0] word);
        return word[6:0] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory return, hazard/redirect controls in,
// fetch address and IF/ID contents out.
//   master : the fetch stage (drives curPC, IF/ID, halted, fetch_count)
//   slave  : memory / hazard unit / EX side
interface fetch_stage_if;
    logic [31:0] instr;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] curPC;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        halted;
    logic [31:0] fetch_count;

    modport master (
        input  instr, stall, flush, redirect_valid, redirect_pc,
        output curPC, if_id_valid, if_id_pc, if_id_pc4, if_id_instr, halted, fetch_count
    );

    modport slave (
        output instr, stall, flush, redirect_valid, redirect_pc,
        input  curPC, if_id_valid, if_id_pc, if_id_pc4, if_id_instr, halted, fetch_count
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with load-enable and bubble insertion.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   load_i        : capture pc_i/instr_i as a valid entry
//   bubble_i      : replace contents with an invalid NOP (wins over load_i)
//   valid_o, pc_o, pc4_o, instr_o : registered entry
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic [31:0] instr_o
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        if (bubble_i) begin
            // pc/pc4 are left as-is; only valid and the word mark the bubble
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            pc4_d   = pc_i + 32'd4;
            instr_d = instr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pc_q    <= 32'd0;
            pc4_q   <= 32'd4;
            instr_q <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Pipeline front end: PC register, next-PC selection, RUN/HALT FSM and
// fetched-instruction counter; IF/ID register is a sub-module.
//   CLK   : pipeline clock
//   Reset : synchronous active-low reset
//   bus   : fetch_stage_if master (memory word, stall/flush/redirect in;
//           curPC, IF/ID, halted, fetch_count out)
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT = 32'd128
) (
    input logic          CLK,
    input logic          Reset,
    fetch_stage_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  count_q, count_d;
    logic         load;
    logic         bubble;

    // Redirect targets are word-aligned by dropping the low bits.
    logic unused_rpc_lo;
    assign unused_rpc_lo = ^bus.redirect_pc[1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        load    = 1'b0;
        bubble  = 1'b0;
        if (bus.redirect_valid) begin
            // A halt seen behind a taken branch was wrong-path: resume running.
            pc_d    = {bus.redirect_pc[31:2], 2'b00};
            bubble  = 1'b1;
            state_d = StRun;
        end else if (state_q == StHalt) begin
            // hold everything
        end else if (bus.flush) begin
            bubble = 1'b1;
            if (!bus.stall) pc_d = pc_q + 32'd4;
        end else if (bus.stall) begin
            // hold everything
        end else if (pc_q >= PC_LIMIT) begin
            bubble  = 1'b1;
            state_d = StHalt;
        end else begin
            load    = 1'b1;
            count_d = count_q + 32'd1;
            if (is_halt(bus.instr)) state_d = StHalt;
            else                    pc_d    = pc_q + 32'd4;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    fetch_stage_if_id_reg u_if_id_reg (
        .clk_i    (CLK),
        .rst_ni   (Reset),
        .load_i   (load),
        .bubble_i (bubble),
        .pc_i     (pc_q),
        .instr_i  (bus.instr),
        .valid_o  (bus.if_id_valid),
        .pc_o     (bus.if_id_pc),
        .pc4_o    (bus.if_id_pc4),
        .instr_o  (bus.if_id_instr)
    );

    assign bus.curPC       = pc_q;
    assign bus.halted      = (state_q == StHalt);
    assign bus.fetch_count = count_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front end of the five-stage RISC-V pipeline: owns the PC register, drives the fetch address to the instruction memory, and captures the returned word into the IF/ID pipeline register consumed by decode.
- Handles hazard stalls from the hazard unit, taken-branch/jump redirects from EX, and halt detection on the end-of-program opcode.
- Keeps a fetched-instruction counter for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_LIMIT, 32'd128, first byte address beyond the instruction ROM; fetch at or past it halts.
- HALT_OPCODE, 7'b1111111, opcode field that marks end of program.
- NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) placed in IF/ID on squash.

Ports:
- CLK  in  1  pipeline clock; all state updates on posedge.
- Reset  in  1  synchronous, active-low reset.
- instr  in  32  word returned by the instruction memory for the current curPC; stable before posedge.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- flush  in  1  squash IF/ID contents to a bubble.
- redirect_valid  in  1  EX resolved a taken branch/jump.
- redirect_pc  in  32  target PC for the redirect.
- curPC  out  32  fetch address to the instruction memory.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  32  PC of the IF/ID instruction.
- if_id_pc4  out  32  if_id_pc + 4, for jal/jalr link.
- if_id_instr  out  32  instruction word in IF/ID (NOP_INSTR when invalid).
- halted  out  1  fetch stopped on halt opcode or PC_LIMIT.
- fetch_count  out  32  number of instructions accepted into IF/ID.

Behaviour:
- Reset (Reset==0 at posedge), which has priority over everything:
  - curPC=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_pc4=4, if_id_instr=NOP_INSTR, halted=0, fetch_count=0, state=RUN.
- FSM states are RUN and HALT. halted==1 exactly when state==HALT.
- Priority at each posedge, after reset: redirect > HALT hold > flush > stall > normal advance.
- Redirect (redirect_valid=1, any state):
  - curPC <= {redirect_pc[31:2],2'b00}; misaligned low bits are dropped.
  - IF/ID <= bubble (valid=0, instr=NOP_INSTR).
  - state <= RUN, because a halt fetched after an older taken branch is wrong-path.
  - stall and flush are ignored that cycle.
- HALT (no redirect): curPC and IF/ID hold; fetch_count holds.
- flush without redirect:
  - IF/ID <= bubble.
  - curPC <= curPC+4 unless stall=1, in which case curPC holds.
- stall without flush/redirect: curPC, IF/ID and fetch_count all hold.
- Normal advance in RUN:
  - IF/ID <= {valid=1, pc=curPC, pc4=curPC+4, instr=instr}.
  - curPC <= curPC+4.
  - fetch_count <= fetch_count+1.
- Halt detection on a normal advance:
  - If instr[6:0]==HALT_OPCODE, the word still enters IF/ID as valid and is counted.
  - curPC holds and state <= HALT.
- PC_LIMIT: if curPC >= PC_LIMIT on a normal advance, IF/ID <= bubble, no count, state <= HALT, curPC holds.
- Latency: one cycle from curPC to the matching IF/ID entry. A redirect costs one bubble in IF/ID, beyond any EX-side flush of ID/EX handled elsewhere.
- Arithmetic: all PC adds are 32-bit modulo 2^32. fetch_count wraps at 2^32-1 -> 0.

Decomposition:
- Shared package holds: NOP_INSTR, HALT_OPCODE, RISC-V opcode constants, and the RUN/HALT state encoding (1-bit enum).
- One natural sub-module: if_id_reg, the IF/ID register with load-enable and bubble-insert inputs, reusable as a template for later stage registers.
- PC/next-PC logic and the FSM stay in fetch_stage.

Test Plan:
- Reset then 4 free-running cycles with instr=0x00800093,0x00206113,0x001101B3,0x402182B3 -> if_id_pc 0,4,8,12 in successive cycles; fetch_count=4; curPC=16.
- Stall held 2 cycles at curPC=8 -> curPC stays 8, if_id_instr unchanged, fetch_count unchanged; release -> advances to 12.
- redirect_valid=1, redirect_pc=0x1E, asserted together with stall=1 at curPC=0x20 -> next curPC=0x1C, if_id_valid=0, if_id_instr=0x00000013.
- instr=0x0000007F at curPC=0x50 -> IF/ID valid with pc 0x50, halted=1 next cycle, curPC frozen at 0x50 for 5 cycles; then redirect to 0x48 -> halted=0, curPC=0x48.
- Run sequential fetch to curPC=0x80 with PC_LIMIT=128 -> bubble inserted, halted=1, fetch_count=32.
- Reset asserted mid-stream at curPC=0x24 with flush=1 -> all outputs at reset values next cycle; fetch resumes from 0 after release.
